// File: rtl/imem_program_loader.sv
// imem_program_loader: receives a length-prefixed byte stream, packs bytes
// big-endian into 32-bit words and writes them to instruction memory starting
// at BASE_ADDR, holding the core in reset until the image is fully loaded.
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN (trailing XOR checksum byte).
module imem_program_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned MAX_WORDS = 16384
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        cpu_hold,
  output logic        done,
  output logic        error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
    S_DONE,
    S_ERROR
`ifdef IMEM_LOADER_CHECKSUM_EN
    , S_CSUM
`endif
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic [15:0] len_q;
  logic [15:0] word_q;
  logic [1:0]  lane_q;
  logic [23:0] buf_q;
  logic        fire;
  logic        start_ok;
  logic        last_word;
  logic [15:0] len_n;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]  csum_q;
`endif

  assign fire      = in_valid && in_ready;
  assign start_ok  = start && (state_q == S_IDLE || state_q == S_DONE || state_q == S_ERROR);
  assign len_n     = {len_q[15:8], in_data};
  assign last_word = (word_q == len_q - 16'd1);

  // Next-state logic and stream handshake; the loader never backpressures while loading
  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) state_d = S_LEN_HI;
      end
      S_LEN_HI: begin
        in_ready = 1'b1;
        if (in_valid) state_d = S_LEN_LO;
      end
      S_LEN_LO: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (len_n == 16'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            state_d = S_CSUM;
`else
            state_d = S_DONE;
`endif
          end else if (32'(len_n) > MAX_WORDS) begin
            state_d = S_ERROR;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        in_ready = 1'b1;
        if (in_valid && lane_q == 2'd3 && last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          state_d = S_CSUM;
`else
          state_d = S_DONE;
`endif
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CSUM: begin
        in_ready = 1'b1;
        if (in_valid) state_d = (in_data == csum_q) ? S_DONE : S_ERROR;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // State register and status outputs, registered so they align with the state they describe
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      done     <= 1'b0;
      error    <= 1'b0;
      cpu_hold <= 1'b0;
    end else begin
      state_q  <= state_d;
      done     <= (state_d == S_DONE) && (state_q != S_DONE);
      error    <= (state_d == S_ERROR);
      cpu_hold <= (state_d != S_IDLE) && (state_d != S_DONE);
    end
  end

  // Length capture, byte packing and the one-cycle-delayed word write
  always_ff @(posedge clk) begin
    if (rst) begin
      len_q     <= 16'd0;
      word_q    <= 16'd0;
      lane_q    <= 2'd0;
      buf_q     <= 24'd0;
      mem_we    <= 1'b0;
      mem_addr  <= BASE_ADDR;
      mem_wdata <= 32'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q    <= 8'd0;
`endif
    end else begin
      mem_we <= 1'b0;
      if (start_ok) begin
        len_q    <= 16'd0;
        word_q   <= 16'd0;
        lane_q   <= 2'd0;
        mem_addr <= BASE_ADDR;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum_q   <= 8'd0;
`endif
      end else if (fire) begin
        case (state_q)
          S_LEN_HI: len_q[15:8] <= in_data;
          S_LEN_LO: len_q[7:0]  <= in_data;
          S_DATA: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q <= csum_q ^ in_data;
`endif
            lane_q <= lane_q + 2'd1;
            case (lane_q)
              2'd0: buf_q[23:16] <= in_data;
              2'd1: buf_q[15:8]  <= in_data;
              2'd2: buf_q[7:0]   <= in_data;
              default: begin
                mem_we    <= 1'b1;
                mem_wdata <= {buf_q, in_data};
                mem_addr  <= BASE_ADDR + {14'd0, word_q, 2'b00};
                word_q    <= word_q + 16'd1;
              end
            endcase
          end
          default: ;
        endcase
      end
    end
  end

endmodule
